// File: rtl/rv_mem_pkg.sv
// Shared memory-access encodings for the RV32IM MA and WB stages.
// Holds load/store size codes, MA state encoding and writeback selector codes.
// No logic; constants and types only.
package rv_mem_pkg;

  // Load/store size encoding carried on MA_MR / MA_MW
  localparam logic [1:0] MEM_NONE = 2'b00;
  localparam logic [1:0] MEM_BYTE = 2'b01;
  localparam logic [1:0] MEM_HALF = 2'b10;
  localparam logic [1:0] MEM_WORD = 2'b11;

  // Writeback source selector, decoded by the WB stage
  localparam logic [1:0] WREG_ALU = 2'b00;
  localparam logic [1:0] WREG_MEM = 2'b01;
  localparam logic [1:0] WREG_PC4 = 2'b10;
  localparam logic [1:0] WREG_IMM = 2'b11;

  // MA stage access state
  typedef enum logic {
    MA_IDLE = 1'b0,
    MA_WAIT = 1'b1
  } ma_state_t;

endpackage

// File: rtl/ma_load_align.sv
// Load data extractor: selects the addressed byte/half of a memory word and extends it.
// Purely combinational, zero latency.
// No handshake; also usable by forwarding logic.
module ma_load_align
  import rv_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] load_val
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  // Move the addressed lane down to bit 0
  assign byte_sh = rdata >> {addr_lo, 3'b000};
  assign half_sh = rdata >> {addr_lo[1], 4'b0000};

  // Extend the selected lane according to size and signedness
  always_comb begin
    load_val = 32'h0;
    case (size)
      MEM_BYTE: load_val = unsigned_ld ? {24'h0, byte_sh[7:0]}
                                       : {{24{byte_sh[7]}}, byte_sh[7:0]};
      MEM_HALF: load_val = unsigned_ld ? {16'h0, half_sh[15:0]}
                                       : {{16{half_sh[15]}}, half_sh[15:0]};
      MEM_WORD: load_val = rdata;
      default:  load_val = 32'h0;
    endcase
  end

endmodule

// File: rtl/ma_stage_unit.sv
// Memory-access stage: drives DMEM handshakes, aligns store data, extracts loads, registers MA/WB.
// Latency: one cycle with no access or zero-wait ACK; otherwise stalls until ACK or timeout abort.
// Backpressure: STALL_MA freezes upstream while an access waits. Macro MA_MISALIGN_TRAP_EN adds misalign trap.
module ma_stage_unit
  import rv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] MA_PC,
  input  logic [4:0]  MA_ADD,
  input  logic [31:0] MA_DATA,
  input  logic [31:0] MA_SIGN,
  input  logic [1:0]  MA_MR,
  input  logic [1:0]  MA_MW,
  input  logic        MA_UNSIGNED,
  input  logic [1:0]  MA_W_REG,
  input  logic        MA_REG_EN,
  output logic        DMEM_REQ,
  output logic        DMEM_WE,
  output logic [31:0] DMEM_ADDR,
  output logic [31:0] DMEM_WDATA,
  output logic [3:0]  DMEM_BE,
  input  logic [31:0] DMEM_RDATA,
  input  logic        DMEM_ACK,
  output logic        STALL_MA,
  output logic [31:0] WB_PC,
  output logic [4:0]  WB_ADD,
  output logic [31:0] WB_ALU,
  output logic [31:0] WB_MEM,
  output logic [1:0]  WB_W_REG,
  output logic        WB_REG_EN,
`ifdef MA_MISALIGN_TRAP_EN
  output logic        MISALIGN,
  output logic [31:0] TRAP_PC,
`endif
  output logic        MEM_ERR
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  ma_state_t      state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;

  logic        access;
  logic        is_store;
  logic [1:0]  size;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] load_val;
  logic        req;
  logic        stall;
  logic        done;
  logic        abort;
  logic        capture;
`ifdef MA_MISALIGN_TRAP_EN
  logic        misalign_c;
  logic        trap;
`endif

  // A store overrides a simultaneous load request
  assign access   = (MA_MR != MEM_NONE) || (MA_MW != MEM_NONE);
  assign is_store = (MA_MW != MEM_NONE);
  assign size     = is_store ? MA_MW : MA_MR;

`ifdef MA_MISALIGN_TRAP_EN
  assign misalign_c = access && (((size == MEM_HALF) && MA_DATA[0]) ||
                                 ((size == MEM_WORD) && (MA_DATA[1:0] != 2'b00)));
`endif

  // Store lane enables and lane-replicated write data
  always_comb begin
    be_c    = 4'b0000;
    wdata_c = MA_SIGN;
    case (size)
      MEM_BYTE: begin
        be_c    = 4'b0001 << MA_DATA[1:0];
        wdata_c = {4{MA_SIGN[7:0]}};
      end
      MEM_HALF: begin
        be_c    = 4'b0011 << {MA_DATA[1], 1'b0};
        wdata_c = {2{MA_SIGN[15:0]}};
      end
      MEM_WORD: begin
        be_c    = 4'b1111;
        wdata_c = MA_SIGN;
      end
      default: begin
        be_c    = 4'b0000;
        wdata_c = MA_SIGN;
      end
    endcase
  end

  ma_load_align u_load_align (
    .rdata       (DMEM_RDATA),
    .addr_lo     (MA_DATA[1:0]),
    .size        (MA_MR),
    .unsigned_ld (MA_UNSIGNED),
    .load_val    (load_val)
  );

  // State register and wait counter; reset drops any half-done access
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= MA_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state decode plus request/stall/completion strobes
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req       = 1'b0;
    stall     = 1'b0;
    done      = 1'b0;
    abort     = 1'b0;
`ifdef MA_MISALIGN_TRAP_EN
    trap      = 1'b0;
`endif
    case (state)
      MA_IDLE: begin
        if (access) begin
`ifdef MA_MISALIGN_TRAP_EN
          if (misalign_c) begin
            trap = 1'b1;
          end else begin
`else
          begin
`endif
            req = 1'b1;
            if (DMEM_ACK) begin
              done = 1'b1;
            end else begin
              stall     = 1'b1;
              state_nxt = MA_WAIT;
              cnt_nxt   = '0;
            end
          end
        end
      end
      MA_WAIT: begin
        req = 1'b1;
        if (DMEM_ACK) begin
          done      = 1'b1;
          state_nxt = MA_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          abort     = 1'b1;
          state_nxt = MA_IDLE;
          cnt_nxt   = '0;
        end else begin
          stall   = 1'b1;
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: begin
        state_nxt = MA_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Reset masks the decoded outputs so memory sees the request vanish at once
  assign DMEM_REQ   = req & ~RESET;
  assign DMEM_WE    = req & is_store & ~RESET;
  assign STALL_MA   = stall & ~RESET;
  assign DMEM_ADDR  = {MA_DATA[31:2], 2'b00};
  assign DMEM_WDATA = wdata_c;
  assign DMEM_BE    = DMEM_REQ ? be_c : 4'b0000;

  // Advance MA/WB on completion or when nothing needs memory
  assign capture = done || ((state == MA_IDLE) && !access);

  // MA/WB pipeline register; any non-advancing cycle becomes a bubble
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      WB_PC     <= 32'h0;
      WB_ADD    <= 5'h0;
      WB_ALU    <= 32'h0;
      WB_MEM    <= 32'h0;
      WB_W_REG  <= 2'b00;
      WB_REG_EN <= 1'b0;
      MEM_ERR   <= 1'b0;
    end else begin
      MEM_ERR <= abort;
      if (capture) begin
        WB_PC     <= MA_PC;
        WB_ADD    <= MA_ADD;
        WB_ALU    <= MA_DATA;
        WB_MEM    <= (done && !is_store) ? load_val : 32'h0;
        WB_W_REG  <= MA_W_REG;
        WB_REG_EN <= MA_REG_EN;
      end else begin
        WB_REG_EN <= 1'b0;
      end
    end
  end

`ifdef MA_MISALIGN_TRAP_EN
  // Misaligned access: one-cycle flag and faulting PC capture
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      MISALIGN <= 1'b0;
      TRAP_PC  <= 32'h0;
    end else begin
      MISALIGN <= trap;
      if (trap) TRAP_PC <= MA_PC;
    end
  end
`endif

endmodule

// File: tb/tb_ma_stage_unit.sv
// Directed bench for the MA stage: stores, loads with waits, timeout abort and reset mid-access.
module tb_ma_stage_unit;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] MA_PC, MA_DATA, MA_SIGN, DMEM_RDATA;
  logic [4:0]  MA_ADD;
  logic [1:0]  MA_MR, MA_MW, MA_W_REG;
  logic        MA_UNSIGNED, MA_REG_EN, DMEM_ACK;
  logic        DMEM_REQ, DMEM_WE, STALL_MA, WB_REG_EN, MEM_ERR;
  logic [31:0] DMEM_ADDR, DMEM_WDATA, WB_PC, WB_ALU, WB_MEM;
  logic [3:0]  DMEM_BE;
  logic [4:0]  WB_ADD;
  logic [1:0]  WB_W_REG;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ma_stage_unit #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(CLK), .RESET(RESET),
    .MA_PC(MA_PC), .MA_ADD(MA_ADD), .MA_DATA(MA_DATA), .MA_SIGN(MA_SIGN),
    .MA_MR(MA_MR), .MA_MW(MA_MW), .MA_UNSIGNED(MA_UNSIGNED),
    .MA_W_REG(MA_W_REG), .MA_REG_EN(MA_REG_EN),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_BE(DMEM_BE), .DMEM_RDATA(DMEM_RDATA),
    .DMEM_ACK(DMEM_ACK), .STALL_MA(STALL_MA),
    .WB_PC(WB_PC), .WB_ADD(WB_ADD), .WB_ALU(WB_ALU), .WB_MEM(WB_MEM),
    .WB_W_REG(WB_W_REG), .WB_REG_EN(WB_REG_EN), .MEM_ERR(MEM_ERR)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] mr, input logic [1:0] mw,
                           input logic uns, input logic ren);
    MA_PC = pc; MA_ADD = rd; MA_DATA = a; MA_SIGN = d;
    MA_MR = mr; MA_MW = mw; MA_UNSIGNED = uns; MA_REG_EN = ren; MA_W_REG = 2'b01;
  endtask

  task automatic test_reset();
    RESET = 1'b1; DMEM_ACK = 1'b0; DMEM_RDATA = 32'h0;
    set_instr(32'h0, 5'd0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 1'b0);
    #12;
    checks++; if (WB_PC !== 32'h0) begin errors++; $display("FAIL reset_wb_pc: got %h want 0", WB_PC); end
    checks++; if (WB_REG_EN !== 1'b0) begin errors++; $display("FAIL reset_wb_reg_en: got %b want 0", WB_REG_EN); end
    checks++; if (MEM_ERR !== 1'b0) begin errors++; $display("FAIL reset_mem_err: got %b want 0", MEM_ERR); end
    checks++; if ({DMEM_REQ, DMEM_WE, STALL_MA} !== 3'b000) begin errors++; $display("FAIL reset_req_we_stall: got %b want 000", {DMEM_REQ, DMEM_WE, STALL_MA}); end
    @(negedge CLK);
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    set_instr(32'h0000_1000, 5'd3, 32'h1234_5678, 32'h0, 2'b00, 2'b00, 1'b0, 1'b1);
    MA_W_REG = 2'b10;
    #1;
    checks++; if ({DMEM_REQ, STALL_MA} !== 2'b00) begin errors++; $display("FAIL pass_req_stall: got %b want 00", {DMEM_REQ, STALL_MA}); end
    tick();
    checks++; if (WB_PC !== 32'h0000_1000) begin errors++; $display("FAIL pass_wb_pc: got %h want 00001000", WB_PC); end
    checks++; if (WB_ADD !== 5'd3) begin errors++; $display("FAIL pass_wb_add: got %0d want 3", WB_ADD); end
    checks++; if (WB_ALU !== 32'h1234_5678) begin errors++; $display("FAIL pass_wb_alu: got %h want 12345678", WB_ALU); end
    checks++; if (WB_MEM !== 32'h0) begin errors++; $display("FAIL pass_wb_mem: got %h want 0", WB_MEM); end
    checks++; if ({WB_W_REG, WB_REG_EN} !== 3'b101) begin errors++; $display("FAIL pass_wreg_en: got %b want 101", {WB_W_REG, WB_REG_EN}); end
  endtask

  task automatic test_sw_zero_wait();
    set_instr(32'h0000_1004, 5'd0, 32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 2'b11, 1'b0, 1'b1);
    DMEM_ACK = 1'b1;
    #1;
    checks++; if ({DMEM_REQ, DMEM_WE, STALL_MA} !== 3'b110) begin errors++; $display("FAIL sw_req_we_stall: got %b want 110", {DMEM_REQ, DMEM_WE, STALL_MA}); end
    checks++; if (DMEM_BE !== 4'b1111) begin errors++; $display("FAIL sw_be: got %b want 1111", DMEM_BE); end
    checks++; if (DMEM_WDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", DMEM_WDATA); end
    checks++; if (DMEM_ADDR !== 32'h0000_0100) begin errors++; $display("FAIL sw_addr: got %h want 00000100", DMEM_ADDR); end
    tick();
    DMEM_ACK = 1'b0;
    checks++; if (WB_REG_EN !== 1'b1) begin errors++; $display("FAIL sw_wb_reg_en: got %b want 1", WB_REG_EN); end
    checks++; if (WB_MEM !== 32'h0) begin errors++; $display("FAIL sw_wb_mem: got %h want 0", WB_MEM); end
  endtask

  // LB at 0x103, ACK presented in the fourth request cycle
  task automatic test_lb_wait(input logic uns, input logic [31:0] exp_mem);
    int stalls = 0;
    set_instr(32'h0000_1008, 5'd5, 32'h0000_0103, 32'h0, 2'b01, 2'b00, uns, 1'b1);
    DMEM_RDATA = 32'h8012_3456;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) DMEM_ACK = 1'b1;
      #1;
      checks++; if (DMEM_REQ !== 1'b1) begin errors++; $display("FAIL lb_req_cycle%0d: got %b want 1", i, DMEM_REQ); end
      if (STALL_MA === 1'b1) stalls++;
      tick();
      if (i == 0) begin
        checks++; if (WB_REG_EN !== 1'b0) begin errors++; $display("FAIL lb_bubble: got %b want 0", WB_REG_EN); end
      end
    end
    DMEM_ACK = 1'b0;
    checks++; if (stalls != 3) begin errors++; $display("FAIL lb_stall_cycles uns=%b: got %0d want 3", uns, stalls); end
    checks++; if (WB_MEM !== exp_mem) begin errors++; $display("FAIL lb_wb_mem uns=%b: got %h want %h", uns, WB_MEM, exp_mem); end
    checks++; if (WB_REG_EN !== 1'b1) begin errors++; $display("FAIL lb_wb_reg_en: got %b want 1", WB_REG_EN); end
  endtask

  task automatic test_sh_lh();
    set_instr(32'h0000_100C, 5'd0, 32'h0000_0102, 32'h0000_ABCD, 2'b00, 2'b10, 1'b0, 1'b0);
    DMEM_ACK = 1'b1;
    #1;
    checks++; if (DMEM_BE !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b want 1100", DMEM_BE); end
    checks++; if (DMEM_WDATA !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wdata: got %h want abcdabcd", DMEM_WDATA); end
    tick();
    set_instr(32'h0000_1010, 5'd6, 32'h0000_0102, 32'h0, 2'b10, 2'b00, 1'b0, 1'b1);
    DMEM_RDATA = 32'hABCD_0000;
    #1;
    checks++; if ({DMEM_WE, STALL_MA} !== 2'b00) begin errors++; $display("FAIL lh_we_stall: got %b want 00", {DMEM_WE, STALL_MA}); end
    tick();
    checks++; if (WB_MEM !== 32'hFFFF_ABCD) begin errors++; $display("FAIL lh_wb_mem: got %h want ffffabcd", WB_MEM); end
    // store wins when both sizes are set: write strobe asserted, WB_MEM cleared
    set_instr(32'h0000_1014, 5'd7, 32'h0000_0100, 32'h0000_0011, 2'b11, 2'b01, 1'b0, 1'b1);
    #1;
    checks++; if ({DMEM_WE, DMEM_BE} !== 5'b10001) begin errors++; $display("FAIL both_store_wins: got %b want 10001", {DMEM_WE, DMEM_BE}); end
    tick();
    checks++; if (WB_MEM !== 32'h0) begin errors++; $display("FAIL both_wb_mem: got %h want 0", WB_MEM); end
    DMEM_ACK = 1'b0;
  endtask

  task automatic test_lw_misaligned();
    set_instr(32'h0000_1018, 5'd8, 32'h0000_0101, 32'h0, 2'b11, 2'b00, 1'b0, 1'b1);
    DMEM_RDATA = 32'h1234_5678; DMEM_ACK = 1'b1;
    #1;
    checks++; if (DMEM_REQ !== 1'b1) begin errors++; $display("FAIL lw_mis_req: got %b want 1", DMEM_REQ); end
    checks++; if (DMEM_ADDR !== 32'h0000_0100) begin errors++; $display("FAIL lw_mis_addr: got %h want 00000100", DMEM_ADDR); end
    tick();
    DMEM_ACK = 1'b0;
    checks++; if (WB_MEM !== 32'h1234_5678) begin errors++; $display("FAIL lw_mis_wb_mem: got %h want 12345678", WB_MEM); end
  endtask

  task automatic test_timeout();
    int stalls = 0;
    int errs_seen = 0;
    bit released = 1'b0;
    set_instr(32'h0000_101C, 5'd9, 32'h0000_0200, 32'h0, 2'b11, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (MEM_ERR === 1'b1) errs_seen++;
      if (STALL_MA !== 1'b1) begin
        released = 1'b1;
        tick();
        break;
      end
      stalls++;
      tick();
    end
    checks++; if (!released) begin errors++; $display("FAIL timeout_release: got no release want release within 40 cycles"); end
    checks++; if (stalls != 16) begin errors++; $display("FAIL timeout_stall_cycles: got %0d want 16", stalls); end
    checks++; if (errs_seen != 0) begin errors++; $display("FAIL timeout_early_err: got %0d want 0", errs_seen); end
    checks++; if (MEM_ERR !== 1'b1) begin errors++; $display("FAIL timeout_mem_err: got %b want 1", MEM_ERR); end
    checks++; if (WB_REG_EN !== 1'b0) begin errors++; $display("FAIL timeout_wb_reg_en: got %b want 0", WB_REG_EN); end
    set_instr(32'h0000_1020, 5'd7, 32'h0000_0055, 32'h0, 2'b00, 2'b00, 1'b0, 1'b1);
    #1;
    checks++; if (STALL_MA !== 1'b0) begin errors++; $display("FAIL timeout_next_stall: got %b want 0", STALL_MA); end
    tick();
    checks++; if (MEM_ERR !== 1'b0) begin errors++; $display("FAIL timeout_err_pulse: got %b want 0", MEM_ERR); end
    checks++; if (WB_ADD !== 5'd7) begin errors++; $display("FAIL timeout_next_add: got %0d want 7", WB_ADD); end
  endtask

  task automatic test_reset_in_wait();
    set_instr(32'h0000_1024, 5'd10, 32'h0000_0300, 32'h0, 2'b11, 2'b00, 1'b0, 1'b1);
    tick();
    tick();
    checks++; if ({DMEM_REQ, STALL_MA} !== 2'b11) begin errors++; $display("FAIL rst_wait_pre: got %b want 11", {DMEM_REQ, STALL_MA}); end
    RESET = 1'b1;
    #1;
    checks++; if ({DMEM_REQ, STALL_MA} !== 2'b00) begin errors++; $display("FAIL rst_wait_req_stall: got %b want 00", {DMEM_REQ, STALL_MA}); end
    checks++; if ({WB_PC, WB_ADD, WB_ALU} !== 69'h0) begin errors++; $display("FAIL rst_wait_wb: got %h %h %h want 0", WB_PC, WB_ADD, WB_ALU); end
    set_instr(32'h0000_1028, 5'd11, 32'h0000_0400, 32'h0, 2'b00, 2'b00, 1'b0, 1'b1);
    @(negedge CLK);
    RESET = 1'b0;
    #1;
    checks++; if (DMEM_REQ !== 1'b0) begin errors++; $display("FAIL rst_wait_idle_after: got %b want 0", DMEM_REQ); end
    tick();
    checks++; if (WB_ADD !== 5'd11) begin errors++; $display("FAIL rst_wait_resume: got %0d want 11", WB_ADD); end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_sw_zero_wait();
    test_lb_wait(1'b0, 32'hFFFF_FF80);
    test_lb_wait(1'b1, 32'h0000_0080);
    test_sh_lh();
    test_lw_misaligned();
    test_timeout();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
